// File: rtl/base64_pkg.sv
// Shared FSM encoding and character constants for the Base64 stream encoder.
package base64_pkg;

    typedef enum logic [1:0] {
        COLLECT,
        EMIT,
        CR,
        LF
    } b64_state_t;

    localparam logic [7:0] B64_PAD = 8'h3D;
    localparam logic [7:0] B64_CR  = 8'h0D;
    localparam logic [7:0] B64_LF  = 8'h0A;

endpackage

// File: rtl/base64_char_map.sv
// Combinational RFC 4648 alphabet lookup: 6-bit sextet to ASCII character.
module base64_char_map #(
    parameter bit URL_SAFE = 1'b0
) (
    input  logic [5:0] sextet,
    output logic [7:0] char_c
);

    // Offsets fold 'A', 'a'-26 and '0'-52 into a single add per range
    always_comb begin
        char_c = 8'h00;
        if (sextet < 6'd26) begin
            char_c = 8'd65 + 8'(sextet);
        end else if (sextet < 6'd52) begin
            char_c = 8'd71 + 8'(sextet);
        end else if (sextet < 6'd62) begin
            char_c = 8'(sextet) - 8'd4;
        end else if (sextet == 6'd62) begin
            char_c = URL_SAFE ? 8'h2D : 8'h2B;
        end else begin
            char_c = URL_SAFE ? 8'h5F : 8'h2F;
        end
    end

endmodule

// File: rtl/base64_stream_encoder.sv
// Streaming Base64 encoder: packs bytes into 24-bit groups, emits ASCII with optional
// '=' padding and CR LF line wrapping, valid/ready on both sides.
module base64_stream_encoder
    import base64_pkg::*;
#(
    parameter int unsigned LINE_LEN = 76,
    parameter bit          URL_SAFE = 1'b0,
    parameter bit          PAD_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last
);

    localparam int unsigned LINE_W = (LINE_LEN > 0) ? $clog2(LINE_LEN + 1) : 1;

    b64_state_t        state, state_nxt;
    logic [23:0]       group_q, group_nxt;
    logic [1:0]        byte_cnt, byte_cnt_nxt;
    logic [1:0]        n_bytes, n_bytes_nxt;
    logic [1:0]        char_idx, char_idx_nxt;
    logic [LINE_W-1:0] line_cnt, line_cnt_nxt, line_inc;
    logic              msg_last, msg_last_nxt;
    logic              grp_open, grp_open_nxt;
    logic              in_ready_nxt, out_valid_nxt, out_last_nxt;
    logic [7:0]        out_data_nxt;
    logic [1:0]        last_idx;
    logic              line_full;
    logic              in_fire, out_fire;
    logic [5:0]        sextet;
    logic [7:0]        char_c;

    base64_char_map #(.URL_SAFE(URL_SAFE)) u_char_map (
        .sextet (sextet),
        .char_c (char_c)
    );

    // Next-state and counter logic
    always_comb begin
        state_nxt    = state;
        group_nxt    = group_q;
        byte_cnt_nxt = byte_cnt;
        n_bytes_nxt  = n_bytes;
        char_idx_nxt = char_idx;
        line_cnt_nxt = line_cnt;
        msg_last_nxt = msg_last;
        grp_open_nxt = grp_open;
        in_fire      = in_valid & in_ready;
        out_fire     = out_valid & out_ready;
        line_inc     = (LINE_LEN != 0) ? line_cnt + LINE_W'(1) : line_cnt;
        line_full    = (LINE_LEN != 0) && (line_inc == LINE_W'(LINE_LEN));
        last_idx     = PAD_EN ? 2'd3 : n_bytes;

        unique case (state)
            COLLECT: begin
                if (in_fire) begin
                    unique case (byte_cnt)
                        2'd0:    group_nxt = {in_data, 16'h0000};
                        2'd1:    group_nxt[15:8] = in_data;
                        default: group_nxt[7:0] = in_data;
                    endcase
                    n_bytes_nxt = byte_cnt + 2'd1;
                    if (in_last || byte_cnt == 2'd2) begin
                        state_nxt    = EMIT;
                        byte_cnt_nxt = 2'd0;
                        char_idx_nxt = 2'd0;
                        msg_last_nxt = in_last;
                    end else begin
                        byte_cnt_nxt = byte_cnt + 2'd1;
                    end
                end
            end
            EMIT: begin
                if (out_fire) begin
                    line_cnt_nxt = line_inc;
                    if (char_idx == last_idx) begin
                        grp_open_nxt = 1'b0;
                        if (msg_last) begin
                            state_nxt    = COLLECT;
                            line_cnt_nxt = '0;
                        end else begin
                            // A following group always exists here, so a full line breaks now
                            state_nxt = line_full ? CR : COLLECT;
                        end
                    end else begin
                        char_idx_nxt = char_idx + 2'd1;
                        grp_open_nxt = 1'b1;
                        state_nxt    = line_full ? CR : EMIT;
                    end
                end
            end
            CR: begin
                if (out_fire) state_nxt = LF;
            end
            LF: begin
                if (out_fire) begin
                    line_cnt_nxt = '0;
                    state_nxt    = grp_open ? EMIT : COLLECT;
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // Sextet select for the character that will be presented next
    always_comb begin
        unique case (char_idx_nxt)
            2'd0:    sextet = group_nxt[23:18];
            2'd1:    sextet = group_nxt[17:12];
            2'd2:    sextet = group_nxt[11:6];
            default: sextet = group_nxt[5:0];
        endcase
    end

    // Output values for the next cycle; holding state reproduces the current outputs
    always_comb begin
        in_ready_nxt  = (state_nxt == COLLECT);
        out_valid_nxt = 1'b0;
        out_data_nxt  = out_data;
        out_last_nxt  = 1'b0;
        unique case (state_nxt)
            EMIT: begin
                out_valid_nxt = 1'b1;
                out_data_nxt  = (char_idx_nxt > n_bytes_nxt) ? B64_PAD : char_c;
                out_last_nxt  = msg_last_nxt && (char_idx_nxt == (PAD_EN ? 2'd3 : n_bytes_nxt));
            end
            CR: begin
                out_valid_nxt = 1'b1;
                out_data_nxt  = B64_CR;
            end
            LF: begin
                out_valid_nxt = 1'b1;
                out_data_nxt  = B64_LF;
            end
            default: begin
                out_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= COLLECT;
            group_q   <= '0;
            byte_cnt  <= '0;
            n_bytes   <= '0;
            char_idx  <= '0;
            line_cnt  <= '0;
            msg_last  <= 1'b0;
            grp_open  <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 8'h00;
            out_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            group_q   <= group_nxt;
            byte_cnt  <= byte_cnt_nxt;
            n_bytes   <= n_bytes_nxt;
            char_idx  <= char_idx_nxt;
            line_cnt  <= line_cnt_nxt;
            msg_last  <= msg_last_nxt;
            grp_open  <= grp_open_nxt;
            in_ready  <= in_ready_nxt;
            out_valid <= out_valid_nxt;
            out_data  <= out_data_nxt;
            out_last  <= out_last_nxt;
        end
    end

endmodule

// File: tb/tb_base64_stream_encoder.sv
// Bench for base64_stream_encoder: four parameterisations driven with directed and random
// messages, checked against a string-level Base64 reference model.
module tb_base64_stream_encoder;

    typedef logic [7:0] bq_t[$];

    localparam int NI    = 4;
    localparam int BOUND = 3000;
    localparam int LL_P  [NI] = '{4, 0, 5, 76};
    localparam bit URL_P [NI] = '{1'b0, 1'b1, 1'b0, 1'b0};
    localparam bit PAD_P [NI] = '{1'b1, 1'b1, 1'b0, 1'b1};

    logic       clk;
    logic       reset;
    logic       in_valid  [NI];
    logic       in_ready  [NI];
    logic [7:0] in_data   [NI];
    logic       in_last   [NI];
    logic       out_valid [NI];
    logic       out_ready [NI];
    logic [7:0] out_data  [NI];
    logic       out_last  [NI];

    int n_checks = 0;
    int n_errors = 0;

    base64_stream_encoder #(.LINE_LEN(LL_P[0]), .URL_SAFE(URL_P[0]), .PAD_EN(PAD_P[0])) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_last(in_last[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]), .out_last(out_last[0]));
    base64_stream_encoder #(.LINE_LEN(LL_P[1]), .URL_SAFE(URL_P[1]), .PAD_EN(PAD_P[1])) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_last(in_last[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]), .out_last(out_last[1]));
    base64_stream_encoder #(.LINE_LEN(LL_P[2]), .URL_SAFE(URL_P[2]), .PAD_EN(PAD_P[2])) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_last(in_last[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_data(out_data[2]), .out_last(out_last[2]));
    base64_stream_encoder #(.LINE_LEN(LL_P[3]), .URL_SAFE(URL_P[3]), .PAD_EN(PAD_P[3])) u_dut3 (
        .clk(clk), .reset(reset), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_data(in_data[3]), .in_last(in_last[3]), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .out_data(out_data[3]), .out_last(out_last[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(8'(s[i]));
        return q;
    endfunction

    // Reference: encode whole message as a string, then break it into lines
    function automatic bq_t b64_model(input bq_t msg, input int line_len, input bit url, input bit pad);
        string alpha;
        bq_t   raw;
        bq_t   res;
        int    n;
        int    v;
        alpha = url ? "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789-_"
                    : "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789+/";
        for (int g = 0; g < msg.size(); g += 3) begin
            n = msg.size() - g;
            if (n > 3) n = 3;
            v = 0;
            for (int j = 0; j < 3; j++) v = v * 256 + ((j < n) ? int'(msg[g + j]) : 0);
            for (int c = 0; c < 4; c++) begin
                if (c <= n) raw.push_back(8'(alpha[(v >> (18 - 6 * c)) & 63]));
                else if (pad) raw.push_back(8'h3D);
            end
        end
        for (int i = 0; i < raw.size(); i++) begin
            if (line_len > 0 && i > 0 && (i % line_len) == 0) begin
                res.push_back(8'h0D);
                res.push_back(8'h0A);
            end
            res.push_back(raw[i]);
        end
        return res;
    endfunction

    task automatic drive(input int k, input bq_t msg, input int gap);
        int i   = 0;
        int cyc = 0;
        int n   = msg.size();
        while (i < n && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
            if (int'($urandom_range(99)) < gap) begin
                in_valid[k] = 1'b0;
            end else begin
                in_valid[k] = 1'b1;
                in_data[k]  = msg[i];
                in_last[k]  = (i == n - 1);
                if (in_ready[k]) i++;
            end
        end
        check("drive_done", 32'(i), 32'(n));
        @(negedge clk);
        in_valid[k] = 1'b0;
        in_last[k]  = 1'b0;
    endtask

    task automatic collect(input int k, input bq_t exp, input int stall);
        int         idx  = 0;
        int         cyc  = 0;
        int         viol = 0;
        bit         done = 1'b0;
        bit         held = 1'b0;
        logic [7:0] hd   = 8'h00;
        logic       hl   = 1'b0;
        while (!done && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
            if (held) begin
                check("stall_valid", 32'(out_valid[k]), 32'd1);
                check("stall_data", 32'(out_data[k]), 32'(hd));
                check("stall_last", 32'(out_last[k]), 32'(hl));
            end
            if (in_ready[k] && out_valid[k]) viol++;
            out_ready[k] = (int'($urandom_range(99)) >= stall);
            held = out_valid[k] && !out_ready[k];
            hd   = out_data[k];
            hl   = out_last[k];
            if (out_valid[k] && out_ready[k]) begin
                if (idx >= exp.size()) begin
                    check("extra_char", 32'(out_data[k]), 32'hFFFF_FFFF);
                    done = 1'b1;
                end else begin
                    check("char", 32'(out_data[k]), 32'(exp[idx]));
                    check("last", 32'(out_last[k]), 32'(idx == exp.size() - 1));
                    if (out_last[k]) done = 1'b1;
                    idx++;
                end
            end
        end
        check("collect_done", 32'(done), 32'd1);
        check("length", 32'(idx), 32'(exp.size()));
        check("in_out_overlap", 32'(viol), 32'd0);
        @(negedge clk);
        out_ready[k] = 1'b0;
        @(negedge clk);
        check("idle_valid", 32'(out_valid[k]), 32'd0);
        check("idle_ready", 32'(in_ready[k]), 32'd1);
    endtask

    task automatic run_msg(input int k, input bq_t msg, input bq_t exp, input int gap, input int stall);
        fork
            drive(k, msg, gap);
            collect(k, exp, stall);
        join
    endtask

    initial begin
        bq_t msg;
        bq_t exp;
        int  cyc;
        int  len;

        reset = 1'b0;
        for (int k = 0; k < NI; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = 8'h00;
            in_last[k]   = 1'b0;
            out_ready[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("rst_in_ready", 32'(in_ready[k]), 32'd0);
            check("rst_out_valid", 32'(out_valid[k]), 32'd0);
            check("rst_out_data", 32'(out_data[k]), 32'd0);
            check("rst_out_last", 32'(out_last[k]), 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NI; k++) check("rel_in_ready", 32'(in_ready[k]), 32'd1);

        // Directed vectors with literal expectations
        run_msg(3, s2q("Man"), s2q("TWFu"), 0, 0);
        run_msg(3, s2q("Ma"), s2q("TWE="), 0, 0);
        run_msg(3, s2q("M"), s2q("TQ=="), 0, 0);
        run_msg(2, s2q("M"), s2q("TQ"), 0, 0);
        msg = '{8'hFB, 8'hFF};
        run_msg(1, msg, s2q("-_8="), 0, 0);
        run_msg(3, msg, s2q("+/8="), 0, 0);
        exp = s2q("TWFu");
        exp.push_back(8'h0D);
        exp.push_back(8'h0A);
        exp = {exp, s2q("TWFu")};
        run_msg(0, s2q("ManMan"), exp, 0, 0);
        run_msg(0, s2q("ManMan"), exp, 40, 50);
        run_msg(3, s2q("Man"), s2q("TWFu"), 30, 60);

        // Reset while a group is being emitted
        drive(3, s2q("Man"), 0);
        out_ready[3] = 1'b0;
        cyc = 0;
        while (!out_valid[3] && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("pre_rst_valid", 32'(out_valid[3]), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid[3]), 32'd0);
        check("arst_out_data", 32'(out_data[3]), 32'd0);
        check("arst_out_last", 32'(out_last[3]), 32'd0);
        check("arst_in_ready", 32'(in_ready[3]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rel2_in_ready", 32'(in_ready[3]), 32'd1);
        run_msg(3, s2q("Ma"), s2q("TWE="), 0, 0);

        // Randomized messages against the reference model
        for (int k = 0; k < NI; k++) begin
            for (int m = 0; m < 6; m++) begin
                msg.delete();
                len = (k == 3 && m == 0) ? 60 : int'($urandom_range(1, 30));
                for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(255)));
                exp = b64_model(msg, LL_P[k], URL_P[k], PAD_P[k]);
                run_msg(k, msg, exp, int'($urandom_range(0, 50)), int'($urandom_range(0, 60)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
